// File: rtl/fod_ctrl_pkg.sv
// Shared types and widths for the FOD bring-up / frequency-hop sequencer.
package fod_ctrl_pkg;

    localparam int unsigned WI    = 7;
    localparam int unsigned WF    = 16;
    localparam int unsigned TW    = 16;
    localparam int unsigned FCW_W = WI + WF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RSTH = 3'd1,
        ST_PCAL = 3'd2,
        ST_DTCC = 3'd3,
        ST_OFST = 3'd4,
        ST_RUN  = 3'd5,
        ST_HOP  = 3'd6
    } fod_seq_state_t;

endpackage

// File: rtl/fod_seq_timer.sv
// Dwell down-counter: reload on state entry (0 clamps to 1), counts to 1 and holds.
module fod_seq_timer
    import fod_ctrl_pkg::*;
#(
    parameter int unsigned W = TW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expire
);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (load) begin
            cnt_nxt = (value == '0) ? W'(1) : value;
        end else if (cnt > W'(1)) begin
            cnt_nxt = cnt - W'(1);
        end
    end

    // expire is registered: it flags that the current cycle is the last of the dwell
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= W'(1);
            expire <= 1'b1;
        end else begin
            cnt    <= cnt_nxt;
            expire <= (cnt_nxt == W'(1));
        end
    end

endmodule

// File: rtl/fod_cal_seq.sv
// FOD bring-up sequencer: reset hold, FCW load, staged calibration enables, RUN with hop handshake.
module fod_cal_seq
    import fod_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [FCW_W-1:0] fcw_in,
    input  logic [TW-1:0]    rst_t,
    input  logic [TW-1:0]    pcal_t,
    input  logic [TW-1:0]    dtc_t,
    input  logic [TW-1:0]    ofst_t,
    input  logic [TW-1:0]    hop_t,
    input  logic             hop_req,
    output logic             hop_ack,
    output logic             narst,
    output logic [FCW_W-1:0] fcw_fod,
    output logic             pcali_en,
    output logic             dtccali_en,
    output logic             ofstcali_en,
    output logic             sys_en,
    output logic             freq_hop,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state
);

    fod_seq_state_t state_q;
    fod_seq_state_t state_nxt;
    logic [TW-1:0]  load_val;
    logic           timer_load;
    logic           expire;
    logic           fcw_load;
    logic           narst_nxt;
    logic           pcal_nxt;
    logic           dtc_nxt;
    logic           ofst_nxt;
    logic           sys_nxt;
    logic           hop_nxt;
    logic           busy_nxt;

    fod_seq_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .value  (load_val),
        .expire (expire)
    );

    // Next-state: abort dominates every transition
    always_comb begin
        state_nxt = state_q;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start)   state_nxt = ST_RSTH;
                ST_RSTH: if (expire)  state_nxt = ST_PCAL;
                ST_PCAL: if (expire)  state_nxt = ST_DTCC;
                ST_DTCC: if (expire)  state_nxt = ST_OFST;
                ST_OFST: if (expire)  state_nxt = ST_RUN;
                ST_RUN:  if (hop_req) state_nxt = ST_HOP;
                ST_HOP:  if (expire)  state_nxt = ST_RUN;
                default:              state_nxt = ST_IDLE;
            endcase
        end
    end

    // Dwell of the state being entered is captured by the timer on the entry edge
    always_comb begin
        load_val = '0;
        case (state_nxt)
            ST_RSTH: load_val = rst_t;
            ST_PCAL: load_val = pcal_t;
            ST_DTCC: load_val = dtc_t;
            ST_OFST: load_val = ofst_t;
            ST_HOP:  load_val = hop_t;
            default: load_val = '0;
        endcase
    end

    assign timer_load = (state_nxt != state_q);
    assign fcw_load   = ((state_q == ST_IDLE) && (state_nxt == ST_RSTH)) ||
                        ((state_q == ST_RUN)  && (state_nxt == ST_HOP));

    // Output decode of the upcoming state so the flops line up with the state register
    always_comb begin
        narst_nxt = 1'b0;
        pcal_nxt  = 1'b0;
        dtc_nxt   = 1'b0;
        ofst_nxt  = 1'b0;
        sys_nxt   = 1'b0;
        hop_nxt   = 1'b0;
        busy_nxt  = 1'b0;
        case (state_nxt)
            ST_RSTH: busy_nxt = 1'b1;
            ST_PCAL: begin
                narst_nxt = 1'b1; pcal_nxt = 1'b1; busy_nxt = 1'b1;
            end
            ST_DTCC: begin
                narst_nxt = 1'b1; pcal_nxt = 1'b1; dtc_nxt = 1'b1; busy_nxt = 1'b1;
            end
            ST_OFST: begin
                narst_nxt = 1'b1; pcal_nxt = 1'b1; dtc_nxt = 1'b1; ofst_nxt = 1'b1;
                busy_nxt  = 1'b1;
            end
            ST_RUN: begin
                narst_nxt = 1'b1; pcal_nxt = 1'b1; dtc_nxt = 1'b1; ofst_nxt = 1'b1;
                sys_nxt   = 1'b1;
            end
            ST_HOP: begin
                narst_nxt = 1'b1; pcal_nxt = 1'b1; dtc_nxt = 1'b1; ofst_nxt = 1'b1;
                sys_nxt   = 1'b1; hop_nxt  = 1'b1; busy_nxt = 1'b1;
            end
            default: narst_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            fcw_fod     <= '0;
            narst       <= 1'b0;
            pcali_en    <= 1'b0;
            dtccali_en  <= 1'b0;
            ofstcali_en <= 1'b0;
            sys_en      <= 1'b0;
            freq_hop    <= 1'b0;
            busy        <= 1'b0;
            hop_ack     <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            narst       <= narst_nxt;
            pcali_en    <= pcal_nxt;
            dtccali_en  <= dtc_nxt;
            ofstcali_en <= ofst_nxt;
            sys_en      <= sys_nxt;
            freq_hop    <= hop_nxt;
            busy        <= busy_nxt;
            hop_ack     <= (state_q == ST_RUN)  && (state_nxt == ST_HOP);
            done        <= (state_q == ST_OFST) && (state_nxt == ST_RUN);
            if (fcw_load) begin
                fcw_fod <= fcw_in;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_fod_cal_seq.sv
// Directed scenarios plus randomized traffic, checked cycle by cycle against a behavioural model.
module tb_fod_cal_seq;
    import fod_ctrl_pkg::*;

    logic             clk = 1'b0;
    logic             rst, start, abort, hop_req;
    logic [FCW_W-1:0] fcw_in;
    logic [TW-1:0]    rst_t, pcal_t, dtc_t, ofst_t, hop_t;
    logic             hop_ack, narst, pcali_en, dtccali_en, ofstcali_en;
    logic             sys_en, freq_hop, busy, done;
    logic [FCW_W-1:0] fcw_fod;
    logic [2:0]       state;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    // model: current state code, cycles left in a dwell, applied FCW, pulse outputs
    int               m_state = 0;
    int               m_left  = 0;
    logic [FCW_W-1:0] m_fcw   = '0;
    bit               m_ack   = 1'b0;
    bit               m_done  = 1'b0;

    always #5 clk = ~clk;

    fod_cal_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .fcw_in      (fcw_in),
        .rst_t       (rst_t),
        .pcal_t      (pcal_t),
        .dtc_t       (dtc_t),
        .ofst_t      (ofst_t),
        .hop_t       (hop_t),
        .hop_req     (hop_req),
        .hop_ack     (hop_ack),
        .narst       (narst),
        .fcw_fod     (fcw_fod),
        .pcali_en    (pcali_en),
        .dtccali_en  (dtccali_en),
        .ofstcali_en (ofstcali_en),
        .sys_en      (sys_en),
        .freq_hop    (freq_hop),
        .busy        (busy),
        .done        (done),
        .state       (state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int dwell_of(input int s);
        logic [TW-1:0] v;
        case (s)
            1:       v = rst_t;
            2:       v = pcal_t;
            3:       v = dtc_t;
            4:       v = ofst_t;
            default: v = hop_t;
        endcase
        return (v == 0) ? 1 : int'(v);
    endfunction

    task automatic model_edge();
        m_ack  = 1'b0;
        m_done = 1'b0;
        if (rst) begin
            m_state = 0;
            m_fcw   = '0;
        end else if (abort) begin
            m_state = 0;
        end else if (m_state == 0) begin
            if (start) begin
                m_state = 1;
                m_fcw   = fcw_in;
                m_left  = dwell_of(1);
            end
        end else if (m_state == 5) begin
            if (hop_req) begin
                m_state = 6;
                m_ack   = 1'b1;
                m_fcw   = fcw_in;
                m_left  = dwell_of(6);
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_state = (m_state == 6) ? 5 : m_state + 1;
                m_done  = (m_state == 5) && !m_ack && (dwell_of(6) >= 0) && (m_left == 0) && (m_state == 5) ? 1'b0 : 1'b0;
                if (m_state != 5) m_left = dwell_of(m_state);
            end
        end
    endtask

    function automatic logic [11:0] exp_outs();
        int s = m_state;
        return {3'(s), m_ack, s >= 2, s >= 2, s >= 3, s >= 4, s >= 5, s == 6,
                (s >= 1 && s <= 4) || s == 6, m_done};
    endfunction

    // one clock: model advances on the same edge, outputs compared 1 time unit later
    task automatic step(input string tag);
        int prev;
        prev = m_state;
        @(posedge clk);
        model_edge();
        if (prev == 4 && m_state == 5) m_done = 1'b1;
        #1;
        check({tag, "_outs"},
              32'({state, hop_ack, narst, pcali_en, dtccali_en, ofstcali_en,
                   sys_en, freq_hop, busy, done}),
              32'(exp_outs()));
        check({tag, "_fcw"}, 32'(fcw_fod), 32'(m_fcw));
    endtask

    task automatic set_dwell(input int a, input int b, input int c, input int d, input int h);
        rst_t  = TW'(a);
        pcal_t = TW'(b);
        dtc_t  = TW'(c);
        ofst_t = TW'(d);
        hop_t  = TW'(h);
    endtask

    initial begin
        int  k;
        int  cnt;
        bit  found;

        rst = 1'b1; start = 1'b0; abort = 1'b0; hop_req = 1'b0; fcw_in = '0;
        set_dwell(4, 10, 8, 6, 3);
        step("reset");
        step("reset");
        rst = 1'b0;
        step("idle");

        // nominal bring-up: DONE lands 28 edges after the START edge
        fcw_in = FCW_W'(32'h84290);
        start  = 1'b1;
        step("bring_start");
        start  = 1'b0;
        found  = 1'b0;
        k      = 0;
        for (int i = 1; i <= 200 && !found; i++) begin
            step("bring");
            if (done) begin
                found = 1'b1;
                k     = i;
            end
        end
        check("bring_done_lat", 32'(k), 32'd28);
        check("bring_fcw", 32'(fcw_fod), 32'h84290);

        // hop with HOP_T=3
        fcw_in  = FCW_W'(32'h90000);
        hop_t   = TW'(3);
        hop_req = 1'b1;
        step("hop_req");
        check("hop_ack_pulse", 32'(hop_ack), 32'd1);
        hop_req = 1'b0;
        cnt = int'(freq_hop);
        k   = int'(done);
        for (int i = 0; i < 4; i++) begin
            step("hop");
            cnt += int'(freq_hop);
            k   += int'(done) + int'(hop_ack);
        end
        check("hop_len", 32'(cnt), 32'd3);
        check("hop_no_done_ack", 32'(k), 32'd0);
        check("hop_fcw", 32'(fcw_fod), 32'h90000);

        // zero dwell: RUN after four edges
        abort = 1'b1;
        step("abort_run");
        abort = 1'b0;
        set_dwell(0, 0, 0, 0, 0);
        start = 1'b1;
        step("zero_start");
        start = 1'b0;
        k = 0;
        found = 1'b0;
        for (int i = 1; i <= 50 && !found; i++) begin
            step("zero");
            if (state == 3'd5) begin
                found = 1'b1;
                k     = i;
            end
        end
        check("zero_run_lat", 32'(k), 32'd4);

        // hop request raised in DTCC is served on the first RUN edge
        abort = 1'b1;
        step("abort2");
        abort = 1'b0;
        set_dwell(2, 2, 2, 2, 1);
        start = 1'b1;
        step("dtcc_start");
        start = 1'b0;
        k = 0;
        found = 1'b0;
        for (int i = 1; i <= 50 && !found; i++) begin
            if (state == 3'd3) hop_req = 1'b1;
            step("dtcc_req");
            if (hop_ack) begin
                found = 1'b1;
                k     = i;
            end
        end
        hop_req = 1'b0;
        check("dtcc_ack_edge", 32'(k), 32'd9);

        // abort in PCAL while START is high, then restart
        abort = 1'b1;
        step("abort3");
        abort  = 1'b0;
        fcw_in = FCW_W'(32'h12345);
        set_dwell(1, 5, 1, 1, 1);
        start = 1'b1;
        step("pcal_start");
        step("pcal_enter");
        step("pcal_in");
        abort = 1'b1;
        step("pcal_abort");
        check("pcal_abort_state", 32'(state), 32'd0);
        check("pcal_abort_fcw", 32'(fcw_fod), 32'h12345);
        abort = 1'b0;
        step("pcal_restart");
        check("pcal_restart_state", 32'(state), 32'd1);
        start = 1'b0;

        // synchronous reset during HOP
        set_dwell(1, 1, 1, 1, 5);
        for (int i = 0; i < 6; i++) step("to_run");
        hop_req = 1'b1;
        step("rst_hop_req");
        hop_req = 1'b0;
        step("in_hop");
        rst = 1'b1;
        step("rst_in_hop");
        check("rst_hop_outs",
              32'({state, hop_ack, narst, pcali_en, dtccali_en, ofstcali_en,
                   sys_en, freq_hop, busy, done}), 32'd0);
        check("rst_hop_fcw", 32'(fcw_fod), 32'd0);
        rst = 1'b0;
        step("post_rst");

        // randomized traffic: dwell values change freely, hop_req held until acknowledged
        for (int i = 0; i < 4000; i++) begin
            rst     = ($urandom_range(0, 299) == 0);
            abort   = ($urandom_range(0, 79) == 0);
            start   = ($urandom_range(0, 3) != 0);
            fcw_in  = FCW_W'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                set_dwell(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                          int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                          int'($urandom_range(0, 4)));
            end
            if (!hop_req) hop_req = ($urandom_range(0, 5) == 0);
            step("rand");
            if (hop_ack || rst) hop_req = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
